exc_unit: RTL and testbench

//  Exception/interrupt sequencer fed by the controller's Exc, EStatus and ERet outputs.

---
 rtl/exc_unit_if.sv | 30 +++
 rtl/exc_unit.sv | 105 ++++++++++
 tb/tb_exc_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/exc_unit_if.sv
// Controller/fetch-side bundle of the exception sequencer: requests and syndrome in,
// PC redirect, system registers and acknowledge out.
interface exc_unit_if #(
  parameter int N = 64
);
  logic         Exc;
  logic         ERet;
  logic [3:0]   EStatus;
  logic         ExtIRQ;
  logic [N-1:0] pc_in;
  logic [1:0]   sys_sel;
  logic         ExcAck;
  logic         exc_redirect;
  logic [N-1:0] exc_target;
  logic [N-1:0] ELR;
  logic [N-1:0] ESR;
  logic         in_handler;
  logic         double_fault;
  logic [N-1:0] sys_rdata;

  modport master (
    output Exc, ERet, EStatus, ExtIRQ, pc_in, sys_sel,
    input  ExcAck, exc_redirect, exc_target, ELR, ESR, in_handler, double_fault, sys_rdata
  );

  modport slave (
    input  Exc, ERet, EStatus, ExtIRQ, pc_in, sys_sel,
    output ExcAck, exc_redirect, exc_target, ELR, ESR, in_handler, double_fault, sys_rdata
  );
endinterface

// File: rtl/exc_unit.sv
// Exception/interrupt sequencer: captures ELR/ESR on entry, redirects the PC to the vector
// or back to ELR, runs the ExtIRQ/ExcAck handshake and masks nested exceptions.
module exc_unit #(
  parameter int           N           = 64,
  parameter logic [N-1:0] VECTOR_ADDR = 'hD8,
  parameter logic [3:0]   IRQ_CODE    = 4'b0001,
  parameter logic [3:0]   UNDEF_CODE  = 4'b0010
) (
  input  logic     clk,
  input  logic     reset,
  exc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    HANDLER_ACK = 2'd1,
    HANDLER     = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [N-1:0] esr_q, esr_d;
  logic         ack_q;
  logic         dfault_q, dfault_d;

  logic         in_handler;
  logic         take;
  logic         eret_ok;
  logic         redirect;
  logic [N-1:0] target;
  logic [N-1:0] rdata;

  assign in_handler = (state_q != RUN);
  assign take       = bus.Exc & (state_q == RUN);
  assign eret_ok    = bus.ERet & in_handler;

  always_comb begin
    state_d  = state_q;
    elr_d    = elr_q;
    esr_d    = esr_q;
    dfault_d = dfault_q;
    redirect = 1'b0;
    target   = '0;
    if (take) begin
      redirect = 1'b1;
      target   = VECTOR_ADDR;
      esr_d    = {{(N-4){1'b0}}, bus.EStatus};
      // An interrupt resumes at the interrupted instruction; a fault skips past it.
      if (bus.EStatus == IRQ_CODE) begin
        elr_d   = bus.pc_in;
        state_d = HANDLER_ACK;
      end else begin
        elr_d   = bus.pc_in + {{(N-3){1'b0}}, 3'd4};
        state_d = HANDLER;
      end
    end else if (eret_ok) begin
      redirect = 1'b1;
      target   = elr_q;
      state_d  = RUN;
    end else begin
      if (in_handler && bus.Exc && (bus.EStatus == UNDEF_CODE)) begin
        dfault_d = 1'b1;
      end
      if ((state_q == HANDLER_ACK) && !bus.ExtIRQ) begin
        state_d = HANDLER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      elr_q    <= '0;
      esr_q    <= '0;
      ack_q    <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elr_q    <= elr_d;
      esr_q    <= esr_d;
      ack_q    <= (state_d == HANDLER_ACK);
      dfault_q <= dfault_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.sys_sel)
      2'd0:    rdata = elr_q;
      2'd1:    rdata = esr_q;
      2'd2:    rdata = {{(N-1){1'b0}}, in_handler};
      default: rdata = '0;
    endcase
  end

  assign bus.ExcAck       = ack_q;
  assign bus.exc_redirect = redirect;
  assign bus.exc_target   = target;
  assign bus.ELR          = elr_q;
  assign bus.ESR          = esr_q;
  assign bus.in_handler   = in_handler;
  assign bus.double_fault = dfault_q;
  assign bus.sys_rdata    = rdata;

endmodule

// File: tb/tb_exc_unit.sv
// Vector table plus scoreboard of post-edge register state for exc_unit,
// followed by a randomized-length interrupt handshake sequence.
module tb_exc_unit;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_unit_if #(.N(N)) bus ();

  exc_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic         rst, exc, eret;
    logic [3:0]   es;
    logic         irq;
    logic [N-1:0] pc;
    logic [1:0]   sel;
    logic         chk_comb;
    logic         redir;
    logic [N-1:0] tgt;
    logic [N-1:0] rdata;
    logic [N-1:0] elr, esr;
    logic         ack, inh, df;
  } vec_t;

  typedef struct {
    logic [N-1:0] elr, esr;
    logic         ack, inh, df;
  } post_t;

  vec_t  vecs[25];
  post_t sb_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic vec_t mk(logic rst, logic exc, logic eret, logic [3:0] es, logic irq,
                              logic [N-1:0] pc, logic [1:0] sel, logic chk_comb, logic redir,
                              logic [N-1:0] tgt, logic [N-1:0] rdata, logic [N-1:0] elr,
                              logic [N-1:0] esr, logic ack, logic inh, logic df);
    vec_t v;
    v.rst = rst; v.exc = exc; v.eret = eret; v.es = es; v.irq = irq; v.pc = pc; v.sel = sel;
    v.chk_comb = chk_comb; v.redir = redir; v.tgt = tgt; v.rdata = rdata;
    v.elr = elr; v.esr = esr; v.ack = ack; v.inh = inh; v.df = df;
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t r);
    post_t p, e;
    @(negedge clk);
    reset       = r.rst;
    bus.Exc     = r.exc;
    bus.ERet    = r.eret;
    bus.EStatus = r.es;
    bus.ExtIRQ  = r.irq;
    bus.pc_in   = r.pc;
    bus.sys_sel = r.sel;
    p.elr = r.elr; p.esr = r.esr; p.ack = r.ack; p.inh = r.inh; p.df = r.df;
    sb_q.push_back(p);
    #1;
    if (r.chk_comb) begin
      chk($sformatf("row%0d exc_redirect", idx), {63'b0, bus.exc_redirect}, {63'b0, r.redir});
      chk($sformatf("row%0d exc_target", idx), bus.exc_target, r.tgt);
      chk($sformatf("row%0d sys_rdata", idx), bus.sys_rdata, r.rdata);
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("row%0d ELR", idx), bus.ELR, e.elr);
    chk($sformatf("row%0d ESR", idx), bus.ESR, e.esr);
    chk($sformatf("row%0d ExcAck", idx), {63'b0, bus.ExcAck}, {63'b0, e.ack});
    chk($sformatf("row%0d in_handler", idx), {63'b0, bus.in_handler}, {63'b0, e.inh});
    chk($sformatf("row%0d double_fault", idx), {63'b0, bus.double_fault}, {63'b0, e.df});
    $display("row %0d: rst=%0b exc=%0b eret=%0b es=%0d irq=%0b pc=%h -> ELR=%h ESR=%h ack=%0b inh=%0b df=%0b",
             idx, r.rst, r.exc, r.eret, r.es, r.irq, r.pc, bus.ELR, bus.ESR, bus.ExcAck,
             bus.in_handler, bus.double_fault);
  endtask

  initial begin
    int hold;
    int waited;
    logic dropped;
    reset = 1'b0; bus.Exc = 1'b0; bus.ERet = 1'b0; bus.EStatus = 4'd0;
    bus.ExtIRQ = 1'b0; bus.pc_in = '0; bus.sys_sel = 2'd0;

    //            rst exc ert es irq pc                     sel cc rd tgt    rdata  ELR    ESR ack inh df
    vecs[0]  = mk(1, 0, 0, 0, 0, 64'h0,                  0, 0, 0, 64'h0,   64'h0,   64'h0,   0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 64'h0,                  0, 1, 0, 64'h0,   64'h0,   64'h0,   0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 2, 0, 64'h40,                 0, 1, 1, 64'hD8,  64'h0,   64'h44,  2, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 64'h48,                 1, 1, 0, 64'h0,   64'h2,   64'h44,  2, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 64'h4C,                 2, 1, 0, 64'h0,   64'h1,   64'h44,  2, 0, 1, 0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 64'h50,                 0, 1, 1, 64'h44,  64'h44,  64'h44,  2, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 64'h44,                 2, 1, 0, 64'h0,   64'h0,   64'h44,  2, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 1, 64'h100,                0, 1, 1, 64'hD8,  64'h44,  64'h100, 1, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 64'hD8,                 1, 1, 0, 64'h0,   64'h1,   64'h100, 1, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 64'hDC,                 2, 1, 0, 64'h0,   64'h1,   64'h100, 1, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 64'hE0,                 0, 1, 0, 64'h0,   64'h100, 64'h100, 1, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 64'hE4,                 0, 1, 0, 64'h0,   64'h100, 64'h100, 1, 0, 1, 0);
    vecs[12] = mk(0, 1, 0, 2, 0, 64'hE0,                 3, 1, 0, 64'h0,   64'h0,   64'h100, 1, 0, 1, 1);
    vecs[13] = mk(0, 0, 1, 0, 0, 64'hE8,                 1, 1, 1, 64'h100, 64'h1,   64'h100, 1, 0, 0, 1);
    vecs[14] = mk(0, 1, 0, 2, 0, 64'h200,                0, 1, 1, 64'hD8,  64'h100, 64'h204, 2, 0, 1, 1);
    vecs[15] = mk(0, 1, 1, 1, 0, 64'h300,                0, 1, 1, 64'h204, 64'h204, 64'h204, 2, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 2, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 64'hD8,  64'h204, 64'h0,   2, 0, 1, 1);
    vecs[17] = mk(0, 0, 1, 0, 0, 64'hD8,                 0, 1, 1, 64'h0,   64'h0,   64'h0,   2, 0, 0, 1);
    vecs[18] = mk(0, 1, 1, 2, 0, 64'h10,                 0, 1, 1, 64'hD8,  64'h0,   64'h14,  2, 0, 1, 1);
    vecs[19] = mk(0, 0, 1, 0, 0, 64'hD8,                 0, 1, 1, 64'h14,  64'h14,  64'h14,  2, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 1, 1, 64'h80,                 0, 1, 1, 64'hD8,  64'h14,  64'h80,  1, 1, 1, 1);
    vecs[21] = mk(0, 0, 1, 0, 1, 64'hD8,                 2, 1, 1, 64'h80,  64'h1,   64'h80,  1, 0, 0, 1);
    vecs[22] = mk(0, 1, 0, 1, 1, 64'h84,                 0, 1, 1, 64'hD8,  64'h80,  64'h84,  1, 1, 1, 1);
    vecs[23] = mk(1, 0, 0, 0, 1, 64'hD8,                 0, 1, 0, 64'h0,   64'h84,  64'h0,   0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 1, 64'h88,                 0, 1, 0, 64'h0,   64'h0,   64'h0,   0, 0, 0, 0);

    for (int i = 0; i < 25; i++) apply(i, vecs[i]);

    // Interrupt held for a random number of cycles; ExcAck must track it, then drop one edge after release.
    @(negedge clk);
    bus.Exc = 1'b1; bus.EStatus = 4'd1; bus.ExtIRQ = 1'b1; bus.pc_in = 64'h500; bus.ERet = 1'b0;
    @(posedge clk); #1;
    chk("seq ExcAck on take", {63'b0, bus.ExcAck}, 64'd1);
    hold = $urandom_range(1, 4);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      bus.Exc = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("seq ExcAck hold%0d", c), {63'b0, bus.ExcAck}, 64'd1);
    end
    @(negedge clk);
    bus.Exc = 1'b0; bus.ExtIRQ = 1'b0;
    waited = 0;
    dropped = 1'b0;
    while (!dropped && waited < 8) begin
      @(posedge clk); #1;
      waited++;
      if (bus.ExcAck == 1'b0) dropped = 1'b1;
    end
    chk("seq ExcAck drop latency", 64'(waited), 64'd1);
    chk("seq in_handler after ack", {63'b0, bus.in_handler}, 64'd1);
    chk("seq ELR irq", bus.ELR, 64'h500);
    $display("seq: irq held %0d extra cycles, ack dropped after %0d edge(s), ELR=%h", hold, waited, bus.ELR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
